// File: rtl/io_in_reader_pkg.sv
// io_in_reader_pkg: port addresses, FI flag position and FSM state codes shared by io_in_reader.
package io_in_reader_pkg;
    localparam logic [15:0] RSR_ADDR = 16'h0ABC;
    localparam logic [15:0] RBR_ADDR = 16'h0ABD;
    localparam int unsigned FI_BIT   = 5;

    typedef logic [3:0] state_t;

    localparam state_t POLL_SET  = 4'd0;
    localparam state_t POLL_RD   = 4'd1;
    localparam state_t POLL_END  = 4'd2;
    localparam state_t POLL_CHK  = 4'd3;
    localparam state_t BUF_RD    = 4'd4;
    localparam state_t BUF_END   = 4'd5;
    localparam state_t SOC_UP    = 4'd6;
    localparam state_t WAIT_EOC0 = 4'd7;
    localparam state_t WAIT_EOC1 = 4'd8;
endpackage

// File: rtl/io_in_reader_if.sv
// io_in_reader_if: I/O read bus plus soc/eoc/ok consumer handshake seen by io_in_reader.
interface io_in_reader_if;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ior_;
    logic        iow_;
    logic [7:0]  x;
    logic        soc;
    logic        eoc;
    logic        ok;
    logic [7:0]  count;

    modport master (output addr, ior_, iow_, x, soc, count, input data, eoc, ok);
    modport slave  (input addr, ior_, iow_, x, soc, count, output data, eoc, ok);
endinterface

// File: rtl/io_in_reader_soc_eoc.sv
// io_in_reader_soc_eoc_master: soc/eoc handshake with the consumer and ok-byte counter.
// IO_IN_READER_COUNT_EN enables the counter; otherwise count_o is tied to 8'h00.
module io_in_reader_soc_eoc_master
    import io_in_reader_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic       start_i,
    input  logic       eoc_i,
`ifdef IO_IN_READER_COUNT_EN
    input  logic       ok_i,
`endif
    output logic       soc_o,
    output logic       done_o,
    output logic [7:0] count_o
);
    // POLL_SET doubles as the idle code: no handshake in flight
    state_t state_q, state_d;
    logic   soc_q, soc_d;
    logic   rise, fall;

    assign rise   = state_q == SOC_UP && eoc_i;
    assign fall   = state_q == WAIT_EOC0 && !eoc_i;
    assign done_o = state_q == WAIT_EOC1 && eoc_i;
    assign soc_o  = soc_q;

    always_comb begin
        state_d = start_i ? SOC_UP : rise ? WAIT_EOC0 : fall ? WAIT_EOC1 : done_o ? POLL_SET : state_q;
        soc_d   = rise | (soc_q & ~fall);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= POLL_SET;
            soc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
        end
    end

`ifdef IO_IN_READER_COUNT_EN
    logic       okr_q;
    logic [7:0] count_q;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            okr_q   <= 1'b0;
            count_q <= 8'h00;
        end else begin
            okr_q   <= fall ? ok_i : okr_q;
            count_q <= done_o && okr_q ? count_q + 8'd1 : count_q;
        end
    end

    assign count_o = count_q;
`else
    assign count_o = 8'h00;
`endif
endmodule

// File: rtl/io_in_reader.sv
// io_in_reader: polls RSR for FI, reads RBR and forwards each byte to the soc/eoc consumer.
// IO_IN_READER_COUNT_EN enables the ok-byte counter on count; without it count reads 8'h00.
module io_in_reader
    import io_in_reader_pkg::*;
(
    input logic            clock,
    input logic            reset_,
    io_in_reader_if.master io
);
    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        ior_q, ior_d;
    logic        fi_q, fi_d;
    logic [7:0]  x_q, x_d;
    logic        done;

    // addr only moves in POLL_SET/POLL_CHK, keeping a full idle clock around every strobe
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ior_d   = ior_q;
        fi_d    = fi_q;
        x_d     = x_q;
        case (state_q)
            POLL_SET: begin
                addr_d  = RSR_ADDR;
                state_d = POLL_RD;
            end
            POLL_RD, BUF_RD: begin
                ior_d   = 1'b0;
                state_d = state_q == POLL_RD ? POLL_END : BUF_END;
            end
            POLL_END: begin
                ior_d   = 1'b1;
                fi_d    = io.data[FI_BIT];
                state_d = POLL_CHK;
            end
            POLL_CHK: begin
                addr_d  = fi_q ? RBR_ADDR : addr_q;
                state_d = fi_q ? BUF_RD : POLL_RD;
            end
            BUF_END: begin
                ior_d   = 1'b1;
                x_d     = io.data;
                state_d = SOC_UP;
            end
            SOC_UP:  state_d = done ? POLL_SET : SOC_UP;
            default: state_d = POLL_SET;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= POLL_SET;
            addr_q  <= 16'h0000;
            ior_q   <= 1'b1;
            fi_q    <= 1'b0;
            x_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ior_q   <= ior_d;
            fi_q    <= fi_d;
            x_q     <= x_d;
        end
    end

    assign io.addr = addr_q;
    assign io.ior_ = ior_q;
    assign io.iow_ = 1'b1;
    assign io.x    = x_q;

    io_in_reader_soc_eoc_master u_hs (
        .clock   (clock),
        .reset_  (reset_),
        .start_i (state_q == BUF_END),
        .eoc_i   (io.eoc),
`ifdef IO_IN_READER_COUNT_EN
        .ok_i    (io.ok),
`endif
        .soc_o   (io.soc),
        .done_o  (done),
        .count_o (io.count)
    );
endmodule

// File: tb/tb_io_in_reader.sv
// tb_io_in_reader: randomized bench for io_in_reader with an input-port device and a consumer model.
// Build with +define+IO_IN_READER_COUNT_EN to expect a live ok-byte count.
module tb_io_in_reader;
    import io_in_reader_pkg::*;

    logic clock  = 1'b0;
    logic reset_ = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clock = ~clock;

    io_in_reader_if bus ();
    io_in_reader dut (.clock(clock), .reset_(reset_), .io(bus));

    logic [7:0] dev_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] dev_head = 8'h00;
    logic [7:0] noise    = 8'h00;
    logic       dev_fi   = 1'b0;
    logic       fi_seen  = 1'b0;

    assign bus.data = bus.addr == RSR_ADDR ? {noise[7:6], dev_fi, noise[4:0]} :
                      bus.addr == RBR_ADDR ? dev_head : noise;

    function void refresh();
        dev_fi   = dev_q.size() != 0;
        dev_head = dev_fi ? dev_q[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        @(posedge clock);
        #1;
        dev_q.push_back(b);
        exp_q.push_back(b);
        refresh();
    endtask

    always @(posedge clock) fi_seen = dev_fi;

    // bus monitor: read bookkeeping, device pops and protocol rule violations
    logic [15:0] p_addr = 16'h0000;
    logic        p_ior = 1'b1, p_soc = 1'b0, last_fi = 1'b0;
    int cyc = 0, fi_edge = -1, soc_edge = -1, proto_err = 0, rsr_reads = 0, rbr_reads = 0;

    always @(negedge clock) begin
        cyc++;
        noise = 8'($urandom);
        if (reset_) begin
            if (bus.iow_ !== 1'b1) proto_err++;
            if ((!p_ior || !bus.ior_) && bus.addr !== p_addr) proto_err++;
            if (!p_ior && !bus.ior_) proto_err++;
            if (p_ior && !bus.ior_ && bus.addr == RBR_ADDR && !last_fi) proto_err++;
            if (!bus.ior_ && bus.addr != RSR_ADDR && bus.addr != RBR_ADDR) proto_err++;
            if (!p_ior && bus.ior_) begin
                if (p_addr == RSR_ADDR) begin
                    rsr_reads++;
                    last_fi = fi_seen;
                    if (fi_seen) fi_edge = cyc;
                end else begin
                    rbr_reads++;
                    last_fi = 1'b0;
                    if (dev_q.size() != 0) void'(dev_q.pop_front());
                    refresh();
                end
            end
            if (bus.soc && !p_soc) soc_edge = cyc;
        end else begin
            last_fi = 1'b0;
        end
        p_addr = bus.addr;
        p_ior  = bus.ior_;
        p_soc  = bus.soc;
    end

    // consumer: answers each soc after cons_delay clocks with a verdict
    logic hold_low = 1'b0, next_ok = 1'b1, rand_ok = 1'b0, cons_ok = 1'b0;
    int   cons_delay = 0, accepted = 0;

    initial begin
        bus.eoc = 1'b1;
        bus.ok  = 1'b0;
        forever begin
            @(negedge clock);
            bus.eoc = !hold_low;
            if (bus.soc && bus.eoc) begin
                repeat (cons_delay) @(negedge clock);
                if (bus.soc) begin
                    cons_ok = rand_ok ? 1'($urandom) : next_ok;
                    bus.eoc = 1'b0;
                    bus.ok  = cons_ok;
                    @(negedge clock);
                    got_q.push_back(bus.x);
                    accepted += int'(cons_ok);
                    bus.eoc = 1'b1;
                    bus.ok  = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] exp_count();
`ifdef IO_IN_READER_COUNT_EN
        return 8'(accepted);
`else
        return 8'h00;
`endif
    endfunction

    task automatic wait_got(input int limit, output bit hit);
        for (int i = 0; i < limit && got_q.size() < exp_q.size(); i++) @(negedge clock);
        hit = got_q.size() >= exp_q.size();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_ = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus.addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", bus.addr); end
        total++; if (bus.ior_ !== 1'b1) begin bad++; $display("FAIL reset_ior got=%b want=1", bus.ior_); end
        total++; if (bus.iow_ !== 1'b1) begin bad++; $display("FAIL reset_iow got=%b want=1", bus.iow_); end
        total++; if (bus.soc !== 1'b0) begin bad++; $display("FAIL reset_soc got=%b want=0", bus.soc); end
        total++; if (bus.x !== 8'h00) begin bad++; $display("FAIL reset_x got=%h want=00", bus.x); end
        total++; if (bus.count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", bus.count); end
        reset_ = 1'b1;
    endtask

    task automatic test_poll_idle;
        int lows, wrong, r0, b0;
        logic soc_hi;
        lows = 0; wrong = 0; soc_hi = 1'b0;
        repeat (3) @(negedge clock);
        r0 = rsr_reads;
        b0 = rbr_reads;
        repeat (30) begin
            @(negedge clock);
            if (!bus.ior_) lows++;
            if (!bus.ior_ && bus.addr !== RSR_ADDR) wrong++;
            soc_hi |= bus.soc;
        end
        total++; if (lows != 10) begin bad++; $display("FAIL poll_rate lows=%0d want=10", lows); end
        total++; if (wrong != 0) begin bad++; $display("FAIL poll_addr wrong=%0d want=0", wrong); end
        total++; if (rsr_reads - r0 != 10) begin bad++; $display("FAIL poll_rsr got=%0d want=10", rsr_reads - r0); end
        total++; if (rbr_reads != b0) begin bad++; $display("FAIL poll_rbr got=%0d want=%0d", rbr_reads, b0); end
        total++; if (soc_hi !== 1'b0) begin bad++; $display("FAIL poll_soc got=%b want=0", soc_hi); end
    endtask

    task automatic test_first_byte;
        bit hit;
        int b0;
        next_ok = 1'b1; rand_ok = 1'b0; cons_delay = 0;
        soc_edge = -1;
        b0 = rbr_reads;
        push(8'h1A);
        wait_got(100, hit);
        total++; if (!hit) begin bad++; $display("FAIL first_timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q[got_q.size()-1] !== 8'h1A) begin bad++; $display("FAIL first_byte got=%h want=1a", got_q[got_q.size()-1]); end
        total++; if (soc_edge - fi_edge != 4) begin bad++; $display("FAIL first_soc_delay got=%0d want=4", soc_edge - fi_edge); end
        total++; if (rbr_reads - b0 != 1) begin bad++; $display("FAIL first_rbr_reads got=%0d want=1", rbr_reads - b0); end
        total++; if (bus.x !== 8'h1A) begin bad++; $display("FAIL first_x_hold got=%h want=1a", bus.x); end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL first_count got=%h want=%h", bus.count, exp_count()); end
    endtask

    task automatic test_ok_zero;
        bit hit;
        next_ok = 1'b0;
        push(8'h33);
        wait_got(100, hit);
        total++; if (!hit) begin bad++; $display("FAIL okzero_timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q[got_q.size()-1] !== 8'h33) begin bad++; $display("FAIL okzero_byte got=%h want=33", got_q[got_q.size()-1]); end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL okzero_count got=%h want=%h", bus.count, exp_count()); end
        next_ok = 1'b1;
    endtask

    task automatic test_eoc_held_low;
        bit hit;
        hold_low = 1'b1;
        repeat (2) @(negedge clock);
        soc_edge = -1;
        push(8'h5C);
        repeat (40) @(negedge clock);
        total++; if (soc_edge != -1 || bus.soc !== 1'b0) begin bad++; $display("FAIL eoclow_soc got=%b want=0", bus.soc); end
        total++; if (bus.x !== 8'h5C) begin bad++; $display("FAIL eoclow_x got=%h want=5c", bus.x); end
        hold_low = 1'b0;
        wait_got(100, hit);
        total++; if (!hit || soc_edge == -1) begin bad++; $display("FAIL eoclow_release got=%0d want=%0d", got_q.size(), exp_q.size()); end
        total++; if (got_q[got_q.size()-1] !== 8'h5C) begin bad++; $display("FAIL eoclow_byte got=%h want=5c", got_q[got_q.size()-1]); end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL eoclow_count got=%h want=%h", bus.count, exp_count()); end
    endtask

    task automatic test_random;
        bit hit;
        int start, errs;
        start = exp_q.size();
        errs = 0;
        rand_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cons_delay = $urandom_range(0, 3);
            push(8'($urandom));
            repeat ($urandom_range(0, 8)) @(negedge clock);
        end
        wait_got(2000, hit);
        total++; if (!hit) begin bad++; $display("FAIL rand_timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = start; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; errs++; if (errs < 5) $display("FAIL rand_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL rand_count got=%h want=%h", bus.count, exp_count()); end
        rand_ok = 1'b0;
        cons_delay = 0;
    endtask

    task automatic test_count_wrap;
        bit hit;
        next_ok = 1'b1;
        for (int i = 0; i < 260; i++) push(8'(i));
        wait_got(8000, hit);
        total++; if (!hit) begin bad++; $display("FAIL wrap_timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL wrap_count got=%h want=%h", bus.count, exp_count()); end
    endtask

    task automatic test_reset_mid;
        int i, n_got;
        cons_delay = 8;
        push(8'h77);
        for (i = 0; i < 60 && bus.soc !== 1'b1; i++) @(negedge clock);
        total++; if (bus.soc !== 1'b1) begin bad++; $display("FAIL midrst_soc_wait got=%b want=1", bus.soc); end
        #2 reset_ = 1'b0;
        #1;
        total++; if (bus.soc !== 1'b0) begin bad++; $display("FAIL midrst_soc got=%b want=0", bus.soc); end
        total++; if (bus.ior_ !== 1'b1) begin bad++; $display("FAIL midrst_ior got=%b want=1", bus.ior_); end
        total++; if (bus.addr !== 16'h0000) begin bad++; $display("FAIL midrst_addr got=%h want=0000", bus.addr); end
        accepted = 0;
        void'(exp_q.pop_back());
        n_got = got_q.size();
        @(negedge clock);
        reset_ = 1'b1;
        for (i = 0; i < 10 && bus.ior_ !== 1'b0; i++) @(negedge clock);
        total++; if (bus.ior_ !== 1'b0 || bus.addr !== RSR_ADDR) begin bad++; $display("FAIL midrst_restart addr=%h ior=%b want=0abc/0", bus.addr, bus.ior_); end
        repeat (20) @(negedge clock);
        total++; if (got_q.size() != n_got) begin bad++; $display("FAIL midrst_lost got=%0d want=%0d", got_q.size(), n_got); end
        total++; if (bus.count !== exp_count()) begin bad++; $display("FAIL midrst_count got=%h want=%h", bus.count, exp_count()); end
        cons_delay = 0;
    endtask

    task automatic test_protocol;
        total++; if (proto_err != 0) begin bad++; $display("FAIL bus_protocol errors=%0d want=0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_poll_idle();
        test_first_byte();
        test_ok_zero();
        test_eoc_held_low();
        test_random();
        test_count_wrap();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
